axi_rd_pattern_checker: RTL and testbench

- Downstream consumer of the DDR AXI test master's read data channel (R); passively taps R beats and checks them against the incrementing-counter pattern the write path stores.
- Checks data value, RLAST position per burst, RRESP and RID; keeps error counters and a first-error snapshot for ChipScope and status registers.
- Sits between the MIG AXI slave R channel and the test master; drives RREADY for the whole read path.

---
 rtl/axi_rd_pattern_checker.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi_rd_pattern_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_pattern_checker.sv
// Passive R-channel checker for the DDR AXI test master: verifies the incrementing
// counter pattern, RLAST position, RRESP and RID. Optional beat-rate meter: RDCHK_RATE_EN.
module axi_rd_pattern_checker #(
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned BURST_LEN_M1   = 127,
    parameter int unsigned FRAME_BEATS_M1 = 777599,
    parameter logic [5:0]  ID_EXP         = 6'd0
`ifdef RDCHK_RATE_EN
    ,
    parameter logic [31:0] RATE_CLK       = 32'd167000000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Init_done,
    input  logic              chk_en,
    input  logic              stop_on_err,
    input  logic              clr_stat,
    input  logic              M_AXI_rvalid,
    input  logic [DATA_W-1:0] M_AXI_rdata,
    input  logic              M_AXI_rlast,
    input  logic [1:0]        M_AXI_rresp,
    input  logic [5:0]        M_AXI_rid,
    output logic              M_AXI_rready,
    output logic [31:0]       beat_cnt,
    output logic [31:0]       burst_cnt,
    output logic [31:0]       err_cnt,
    output logic [15:0]       last_err_cnt,
    output logic [15:0]       resp_err_cnt,
    output logic [31:0]       first_err_idx,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_got,
    output logic              err_flag,
    output logic              halted,
`ifdef RDCHK_RATE_EN
    output logic [31:0]       rd_beat_ps,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [7:0]  BL_M1 = 8'(BURST_LEN_M1);
    localparam logic [31:0] FR_M1 = 32'(FRAME_BEATS_M1);

    state_t state_q, state_d;

    logic [2:0]        init_sync_q;
    logic              init_s;
    logic              accept;
    logic              chk_beat;
    logic              enter_check;
    logic              data_err, last_err, resp_err, any_err;
    logic [DATA_W-1:0] exp_ext;

    logic [31:0]       exp_q, exp_d;
    logic [7:0]        idx_q, idx_d;
    logic              aligned_q, aligned_d;
    logic              boundary_q, boundary_d;
    logic [31:0]       beat_cnt_q, beat_cnt_d;
    logic [31:0]       burst_cnt_q, burst_cnt_d;
    logic [31:0]       err_cnt_q, err_cnt_d;
    logic [15:0]       last_err_q, last_err_d;
    logic [15:0]       resp_err_q, resp_err_d;
    logic [31:0]       fe_idx_q, fe_idx_d;
    logic [DATA_W-1:0] fe_exp_q, fe_exp_d;
    logic [DATA_W-1:0] fe_got_q, fe_got_d;
    logic              snap_q, snap_d;
    logic              err_flag_q, err_flag_d;

    // Init_done comes from the MIG calibration domain.
    always_ff @(posedge clk) begin
        if (rst) init_sync_q <= 3'b000;
        else     init_sync_q <= {init_sync_q[1:0], Init_done};
    end

    assign init_s       = init_sync_q[2];
    assign M_AXI_rready = init_s;
    assign accept       = M_AXI_rvalid & M_AXI_rready;
    assign exp_ext      = DATA_W'(exp_q);

    assign chk_beat = accept && (state_q == S_CHECK) && aligned_q;
    assign data_err = chk_beat && (M_AXI_rdata != exp_ext);
    assign last_err = chk_beat && (M_AXI_rlast ? (idx_q != BL_M1) : (idx_q == BL_M1));
    assign resp_err = chk_beat && ((M_AXI_rresp != 2'b00) || (M_AXI_rid != ID_EXP));
    assign any_err  = data_err | last_err | resp_err;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!init_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (chk_en) state_d = S_CHECK;
                S_CHECK: begin
                    if (!chk_en)                    state_d = S_IDLE;
                    else if (any_err && stop_on_err) state_d = S_HALT;
                end
                S_HALT:  if (clr_stat || !chk_en) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign enter_check = (state_q != S_CHECK) && (state_d == S_CHECK);

    // Burst boundaries are tracked on every accepted beat, including drained ones,
    // so a late entry into CHECK knows whether it landed mid-burst.
    always_comb begin
        boundary_d = accept ? M_AXI_rlast : boundary_q;

        exp_d     = exp_q;
        idx_d     = idx_q;
        aligned_d = aligned_q;
        if (enter_check) begin
            exp_d     = 32'd0;
            idx_d     = 8'd0;
            aligned_d = boundary_d;
        end else if (chk_beat) begin
            exp_d = (exp_q == FR_M1) ? 32'd0 : exp_q + 32'd1;
            if (M_AXI_rlast)        idx_d = 8'd0;
            else if (idx_q != 8'hFF) idx_d = idx_q + 8'd1;
        end else if (accept && (state_q == S_CHECK) && M_AXI_rlast) begin
            aligned_d = 1'b1;
        end

        beat_cnt_d  = beat_cnt_q;
        burst_cnt_d = burst_cnt_q;
        err_cnt_d   = err_cnt_q;
        last_err_d  = last_err_q;
        resp_err_d  = resp_err_q;
        fe_idx_d    = fe_idx_q;
        fe_exp_d    = fe_exp_q;
        fe_got_d    = fe_got_q;
        snap_d      = snap_q;
        err_flag_d  = err_flag_q;
        if (clr_stat) begin
            beat_cnt_d  = '0;
            burst_cnt_d = '0;
            err_cnt_d   = '0;
            last_err_d  = '0;
            resp_err_d  = '0;
            fe_idx_d    = '0;
            fe_exp_d    = '0;
            fe_got_d    = '0;
            snap_d      = 1'b0;
            err_flag_d  = 1'b0;
        end else if (chk_beat) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
            if (M_AXI_rlast) burst_cnt_d = burst_cnt_q + 32'd1;
            if (data_err && (err_cnt_q != '1))  err_cnt_d  = err_cnt_q + 32'd1;
            if (last_err && (last_err_q != '1)) last_err_d = last_err_q + 16'd1;
            if (resp_err && (resp_err_q != '1)) resp_err_d = resp_err_q + 16'd1;
            if (data_err && !snap_q) begin
                fe_idx_d = beat_cnt_q;
                fe_exp_d = exp_ext;
                fe_got_d = M_AXI_rdata;
                snap_d   = 1'b1;
            end
            if (any_err) err_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q       <= '0;
            idx_q       <= '0;
            aligned_q   <= 1'b0;
            boundary_q  <= 1'b1;
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
            err_cnt_q   <= '0;
            last_err_q  <= '0;
            resp_err_q  <= '0;
            fe_idx_q    <= '0;
            fe_exp_q    <= '0;
            fe_got_q    <= '0;
            snap_q      <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            exp_q       <= exp_d;
            idx_q       <= idx_d;
            aligned_q   <= aligned_d;
            boundary_q  <= boundary_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            err_cnt_q   <= err_cnt_d;
            last_err_q  <= last_err_d;
            resp_err_q  <= resp_err_d;
            fe_idx_q    <= fe_idx_d;
            fe_exp_q    <= fe_exp_d;
            fe_got_q    <= fe_got_d;
            snap_q      <= snap_d;
            err_flag_q  <= err_flag_d;
        end
    end

    assign beat_cnt      = beat_cnt_q;
    assign burst_cnt     = burst_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign last_err_cnt  = last_err_q;
    assign resp_err_cnt  = resp_err_q;
    assign first_err_idx = fe_idx_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_got = fe_got_q;
    assign err_flag      = err_flag_q;
    assign halted        = (state_q == S_HALT);
    assign dbg_state     = state_q;

`ifdef RDCHK_RATE_EN
    logic [31:0] win_q, win_d;
    logic [31:0] win_beats_q, win_beats_d;
    logic [31:0] rate_q, rate_d;

    // The boundary cycle latches the window and its own beat is not counted.
    always_comb begin
        win_d       = win_q + 32'd1;
        win_beats_d = win_beats_q + {31'd0, accept};
        rate_d      = rate_q;
        if (win_q == RATE_CLK) begin
            win_d       = 32'd0;
            win_beats_d = 32'd0;
            rate_d      = win_beats_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q       <= '0;
            win_beats_q <= '0;
            rate_q      <= '0;
        end else begin
            win_q       <= win_d;
            win_beats_q <= win_beats_d;
            rate_q      <= rate_d;
        end
    end

    assign rd_beat_ps = rate_q;
`endif

endmodule

// File: tb/tb_axi_rd_pattern_checker.sv
// Bench for axi_rd_pattern_checker: directed sequence with randomized gaps and error
// positions, checked against a beat-level reference model of the checker rules.
module tb_axi_rd_pattern_checker;

  localparam int DW = 64;
  localparam int BL = 127;
  localparam int FR = 599;

  logic          clk = 1'b0;
  logic          rst;
  logic          Init_done, chk_en, stop_on_err, clr_stat;
  logic          rvalid, rlast, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [5:0]    rid;
  logic [31:0]   beat_cnt, burst_cnt, err_cnt, first_err_idx;
  logic [15:0]   last_err_cnt, resp_err_cnt;
  logic [DW-1:0] first_err_exp, first_err_got;
  logic          err_flag, halted;
  logic [1:0]    dbg_state;
`ifdef RDCHK_RATE_EN
  logic [31:0]   rd_beat_ps;
`endif

  always #5 clk = ~clk;

  axi_rd_pattern_checker #(
    .DATA_W(DW), .BURST_LEN_M1(BL), .FRAME_BEATS_M1(FR)
`ifdef RDCHK_RATE_EN
    , .RATE_CLK(32'd1000)
`endif
  ) dut (
    .clk(clk), .rst(rst), .Init_done(Init_done), .chk_en(chk_en),
    .stop_on_err(stop_on_err), .clr_stat(clr_stat),
    .M_AXI_rvalid(rvalid), .M_AXI_rdata(rdata), .M_AXI_rlast(rlast),
    .M_AXI_rresp(rresp), .M_AXI_rid(rid), .M_AXI_rready(rready),
    .beat_cnt(beat_cnt), .burst_cnt(burst_cnt), .err_cnt(err_cnt),
    .last_err_cnt(last_err_cnt), .resp_err_cnt(resp_err_cnt),
    .first_err_idx(first_err_idx), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got), .err_flag(err_flag), .halted(halted),
`ifdef RDCHK_RATE_EN
    .rd_beat_ps(rd_beat_ps),
`endif
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: what the checker should have seen and concluded.
  bit          m_checking, m_halted, m_aligned, m_boundary, m_stop, m_snap, m_flag;
  longint      m_beat, m_burst, m_err, m_lerr, m_rerr, m_fidx;
  int          m_pos, m_bidx;
  logic [63:0] m_fexp, m_fgot;
  int          s_pos;  // stream position of the data the writer stored

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_stats();
    m_beat = 0; m_burst = 0; m_err = 0; m_lerr = 0; m_rerr = 0;
    m_snap = 0; m_fidx = 0; m_fexp = 0; m_fgot = 0; m_flag = 0;
  endtask

  task automatic model_start();
    m_checking = 1; m_halted = 0; m_pos = 0; m_bidx = 0; m_aligned = m_boundary;
  endtask

  task automatic model_beat(input logic [63:0] d, input bit last, input logic [1:0] resp,
                            input logic [5:0] id);
    bit de, le, re;
    if (m_checking && m_aligned) begin
      de = (d != 64'(m_pos));
      le = last ? (m_bidx != BL) : (m_bidx == BL);
      re = (resp != 2'b00) || (id != 6'd0);
      if (de) begin
        m_err++;
        if (!m_snap) begin
          m_snap = 1; m_fidx = m_beat; m_fexp = 64'(m_pos); m_fgot = d;
        end
      end
      if (le) m_lerr++;
      if (re) m_rerr++;
      m_beat++;
      m_pos = (m_pos + 1) % (FR + 1);
      if (last) begin
        m_burst++;
        m_bidx = 0;
      end else if (m_bidx < 255) begin
        m_bidx++;
      end
      if (de || le || re) begin
        m_flag = 1;
        if (m_stop) begin
          m_checking = 0; m_halted = 1;
        end
      end
    end else if (m_checking && last) begin
      m_aligned = 1;
    end
    m_boundary = last;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      rvalid = 0; rdata = {$urandom, $urandom}; rlast = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic beat(input logic [63:0] d, input bit last, input logic [1:0] resp,
                      input logic [5:0] id);
    idle($urandom_range(0, 2));
    rvalid = 1; rdata = d; rlast = last; rresp = resp; rid = id;
    @(posedge clk);
    model_beat(d, last, resp, id);
    #1;
    rvalid = 0; rresp = 0; rid = 0;
  endtask

  task automatic send_burst(input int n, input int last_pos, input int bad_pos,
                            input logic [63:0] bad_val, input int resp_pos, input int id_pos);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = (i == bad_pos) ? bad_val : 64'(s_pos);
      s_pos = (s_pos + 1) % (FR + 1);
      beat(d, i == last_pos, (i == resp_pos) ? 2'b10 : 2'b00, (i == id_pos) ? 6'd5 : 6'd0);
    end
  endtask

  task automatic set_check(input bit en);
    chk_en = en;
    idle(3);
    if (en && !m_checking && !m_halted) model_start();
    if (!en) begin
      m_checking = 0; m_halted = 0;
    end
  endtask

  task automatic clear();
    clr_stat = 1;
    @(posedge clk); #1;
    clr_stat = 0;
    model_clear_stats();
    if (m_halted) begin
      m_halted = 0;
      if (chk_en) model_start();
    end
    idle(3);
  endtask

  task automatic compare_all(input string tag);
    idle(2);
    check({tag, "_beat"},  beat_cnt,      64'(m_beat));
    check({tag, "_burst"}, burst_cnt,     64'(m_burst));
    check({tag, "_err"},   err_cnt,       64'(m_err));
    check({tag, "_lerr"},  last_err_cnt,  64'(m_lerr));
    check({tag, "_rerr"},  resp_err_cnt,  64'(m_rerr));
    check({tag, "_flag"},  err_flag,      64'(m_flag));
    check({tag, "_halt"},  halted,        64'(m_halted));
    check({tag, "_fidx"},  first_err_idx, 64'(m_fidx));
    check({tag, "_fexp"},  first_err_exp, m_fexp);
    check({tag, "_fgot"},  first_err_got, m_fgot);
  endtask

  initial begin
    int rp, ip, dp;
    rst = 1; Init_done = 0; chk_en = 0; stop_on_err = 0; clr_stat = 0;
    rvalid = 0; rdata = 0; rlast = 0; rresp = 0; rid = 0;
    m_checking = 0; m_halted = 0; m_aligned = 0; m_boundary = 1; m_stop = 0;
    model_clear_stats();
    s_pos = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rready", rready, 0);
    check("rst_state", dbg_state, 0);
    compare_all("rst");
    rst = 0;

    Init_done = 1;
    idle(5);
    check("init_rready", rready, 1);
    set_check(1);
    check("check_state", dbg_state, 1);

    // Clean pattern, four full bursts.
    s_pos = 0;
    for (int b = 0; b < 4; b++) send_burst(128, BL, -1, 0, -1, -1);
    compare_all("clean");
    check("clean_beat512", beat_cnt, 512);
    check("clean_burst4", burst_cnt, 4);

    // Single data corruption at beat 300, keep going.
    set_check(0); clear(); set_check(1);
    s_pos = 0;
    for (int b = 0; b < 4; b++) send_burst(128, BL, (b == 2) ? 44 : -1, 64'hDEAD, -1, -1);
    compare_all("corrupt");
    check("corrupt_idx", first_err_idx, 300);
    check("corrupt_exp", first_err_exp, 300);
    check("corrupt_got", first_err_got, 64'hDEAD);

    // Same corruption with stop_on_err.
    set_check(0); clear();
    stop_on_err = 1; m_stop = 1;
    set_check(1);
    s_pos = 0;
    send_burst(128, BL, -1, 0, -1, -1);
    send_burst(128, BL, -1, 0, -1, -1);
    for (int i = 0; i < 128; i++) begin
      beat((i == 44) ? 64'hDEAD : 64'(s_pos), i == BL, 2'b00, 6'd0);
      s_pos = (s_pos + 1) % (FR + 1);
      if (i == 43) check("halt_before", halted, 0);
      if (i == 44) check("halt_after", halted, 1);
    end
    compare_all("stop");
    check("stop_beat301", beat_cnt, 301);
    clear();
    check("stop_clr_halt", halted, 0);
    check("stop_clr_beat", beat_cnt, 0);
    stop_on_err = 0; m_stop = 0;
    set_check(0);

    // Early RLAST on beat 100, then a regular burst.
    clear(); set_check(1);
    s_pos = 0;
    send_burst(101, 100, -1, 0, -1, -1);
    send_burst(128, BL, -1, 0, -1, -1);
    compare_all("rlast");
    check("rlast_lerr1", last_err_cnt, 1);

    // Frame wrap with random response, ID and data errors.
    set_check(0); clear(); set_check(1);
    s_pos = 0;
    rp = $urandom_range(0, 127);
    ip = $urandom_range(0, 127);
    dp = $urandom_range(0, 127);
    for (int b = 0; b < 6; b++)
      send_burst(128, BL, (b == 5) ? dp : -1, 64'hF000_0000_0000_0000 | 64'($urandom),
                 (b == 3) ? rp : -1, (b == 4) ? ip : -1);
    compare_all("wrap");
    check("wrap_rerr2", resp_err_cnt, 2);
    check("wrap_err1", err_cnt, 1);

    // Entry mid-burst: the rest of that burst is dropped.
    set_check(0); clear();
    send_burst(50, -1, -1, 0, -1, -1);
    set_check(1);
    send_burst(78, 77, -1, 0, -1, -1);
    s_pos = 0;
    send_burst(128, BL, -1, 0, -1, -1);
    compare_all("align");
    check("align_beat128", beat_cnt, 128);

    // Calibration lost: drain stops, statistics stay.
    Init_done = 0;
    idle(4);
    m_checking = 0;
    check("init_low_rready", rready, 0);
    check("init_low_state", dbg_state, 0);
    compare_all("initlow");

`ifdef RDCHK_RATE_EN
    Init_done = 1; chk_en = 0;
    idle(5);
    rvalid = 1; rlast = 0;
    repeat (2200) @(posedge clk);
    #1;
    rvalid = 0;
    check("rate", rd_beat_ps, 1000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
